sc1_soc_lite: RTL and testbench
===============================

# sc1_soc_lite

Single-clock system-on-chip wrapper around the existing `sc1_cpu` core. It holds the instruction and data RAMs, an I/O register file driving the LEDs, and a UART receiver running a framed write protocol. Over this UART a host can hold the CPU in reset, take ownership of the memories, download a program and data, and then hand control back and resume the CPU. It is the top-level block instantiated by board wrappers and the system bench.

## Interface
- `UART_CLK_HZ`, 50000000: system clock frequency.
- `UART_SCLK_HZ`, 115200: UART baud rate. Bit period is UART_CLK_HZ/UART_SCLK_HZ cycles, and must be ≥2.
- `UART_COUNTER_WIDTH`, 9: width of the baud counter.
- `WIDTH_D`, 32: data and instruction word width.
- `DEPTH_I`, 12: log2 of instruction RAM words.
- `DEPTH_D`, 12: log2 of data RAM words.
- `DEPTH_IO_REG`, 4: log2 of I/O register count.
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `uart_rxd`  in  1: UART receive line, 8N1, idle high.
- `uart_txd`  out  1: UART transmit line, 8N1, idle high.
- `led`  out  10: driven by io_reg_w[0][9:0].

## Operation
- **UART receiver**
  - Synchronize `uart_rxd` through 2 flops.
  - A falling edge starts a frame. Sample at mid-bit: 8 data bits LSB first, then the stop bit.
  - A byte with a bad (low) stop bit is discarded.
- **Loader FSM states:** IDLE, ADDR0..3, DATA0..3, END.
  - IDLE: a received 0xAA advances to ADDR0. Any other byte is ignored.
  - ADDR0..3 and DATA0..3: collect a 32-bit address and 32-bit data, each little-endian.
  - END: a byte of 0x55 performs one write. Any other byte drops the frame. Either way, return to IDLE.
- **Loader address map** (full 32-bit compare):
  - 0x4000 + n, n < 2^DEPTH_I: instruction RAM word n. Written only when master = 0.
  - 0x0000 + n, n < 2^DEPTH_D: data RAM word n. Written only when master = 0.
  - 0x5000: cpu_reset ← data[0].
  - 0x5001: resume ← data[0].
  - 0x5002: master ← data[0]. 0 = loader owns both RAMs; 1 = CPU owns them.
  - All other addresses: ignored.
- **CPU integration**
  - CPU reset = `reset` OR cpu_reset.
  - The CPU `resume` input is the resume register.
  - When master = 1, the CPU I-port and D-port drive the RAMs.
  - When master = 0, the loader drives the RAMs and CPU accesses are ignored. CPU read data is still returned from the RAM outputs.
- **CPU data address map**
  - Address bit DEPTH_D = 0: data RAM.
  - Address bit DEPTH_D = 1: I/O register addr[DEPTH_IO_REG-1:0].
  - io_reg_w[0]: LED register.
  - io_reg_w[1]: writing it loads a TX byte (bits [7:0]) and starts transmission.
  - I/O read index 2: returns the TX busy flag in bit 0.
  - Other I/O reads: return the io_reg_w contents.
- **UART TX:** 8N1 at the same baud rate. A write to io_reg_w[1] while busy is dropped.

## Timing
- Reset values: cpu_reset = 0, resume = 0, master = 1, all io_reg_w = 0, `led` = 0, `uart_txd` = 1, loader FSM in IDLE, TX idle.
- RAMs: synchronous write; registered read with 1-cycle latency.
- Loader and control register writes:
  - Take effect on the clock edge after the stop-bit sample of the 0x55 byte.
  - A control register change is visible to the CPU on the following cycle.
- The loader performs at most one write per frame. A new frame may start immediately after the END byte.
- Reset asserted mid-frame: abort the frame and return to IDLE; no write occurs.
- Toggling master mid-CPU-access: the access in flight is dropped. No arbitration is required.

## Structure
- Shared package holds:
  - Loader constants: START_BYTE 0xAA, END_BYTE 0x55, ADDR_I_BASE 0x4000, ADDR_D_BASE 0x0000, ADDR_CPU_RESET 0x5000, ADDR_RESUME 0x5001, ADDR_MASTER 0x5002.
  - The I/O register indices.
- Sub-modules:
  - `uart_rx`, a natural single sub-module parameterized by clock, baud and counter width.
  - The existing `sc1_cpu`.
  - Generic single-port RAMs named `mem_i` and `mem_d`.
  - TX logic, either inline or as `uart_tx`.

## Test plan
- **Control writes:** bit period 2 cycles. Send frame 0x5000 ← 1, then 0x5002 ← 0 → cpu_reset = 1 and master = 0, and the CPU is held in reset.
- **Instruction download:** load 14 words at 0x4000–0x400D, starting with 0x30040003 at 0x4000 → mem_i[0] = 0x30040003 and mem_i[13] = 0x00000001, verified hierarchically.
- **Bad frames:** frame with end byte 0x56, address 0x4000, data 0xDEADBEEF → mem_i[0] is unchanged. A leading byte of 0x12 before 0xAA is ignored.
- **Hand-back sequence:** 0x5002 ← 1, 0x5000 ← 0, 0x5001 ← 1, 0x5001 ← 0 → the CPU starts fetching at address 0, and resume shows a 1-frame pulse.
- **LED store:** CPU program stores 0x2A5 to io_reg_w[0] → `led` = 0x2A5 on the cycle after the store.
- **Mid-frame reset:** assert `reset` during DATA2 → FSM in IDLE, no RAM write, and all control registers back at their reset values.

Source files
------------

// File: rtl/sc1_soc_lite_pkg.sv
// Shared constants and state encodings for the sc1_soc_lite wrapper, its UART
// receiver and the small sc1_cpu core.
package sc1_soc_lite_pkg;

   localparam logic [7:0]  START_BYTE     = 8'hAA;
   localparam logic [7:0]  END_BYTE       = 8'h55;
   localparam logic [31:0] ADDR_I_BASE    = 32'h0000_4000;
   localparam logic [31:0] ADDR_D_BASE    = 32'h0000_0000;
   localparam logic [31:0] ADDR_CPU_RESET = 32'h0000_5000;
   localparam logic [31:0] ADDR_RESUME    = 32'h0000_5001;
   localparam logic [31:0] ADDR_MASTER    = 32'h0000_5002;

   localparam int IO_LED     = 0;
   localparam int IO_TX      = 1;
   localparam int IO_TX_STAT = 2;

   // CPU opcodes live in instruction bits [31:28]
   localparam logic [3:0] OP_LI  = 4'h1;
   localparam logic [3:0] OP_SW  = 4'h2;
   localparam logic [3:0] OP_LW  = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;

   typedef enum logic [3:0] {
      LD_IDLE, LD_ADDR0, LD_ADDR1, LD_ADDR2, LD_ADDR3,
      LD_DATA0, LD_DATA1, LD_DATA2, LD_DATA3, LD_END
   } ld_state_e;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   typedef enum logic [1:0] {CPU_HALT, CPU_FETCH, CPU_EXEC, CPU_LOAD} cpu_state_e;

endpackage

// File: rtl/sc1_cpu.sv
// Minimal sc1 core: 4 registers, LI/SW/LW/JMP, idles after reset until resume.
// Instruction word: [31:28] op, [25:24] rd, [15:0] imm (zero-extended).
module sc1_cpu
   import sc1_soc_lite_pkg::*;
#(
   parameter int WIDTH_D = 32,
   parameter int DEPTH_I = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               resume,
   output logic [DEPTH_I-1:0] i_addr,
   input  logic [WIDTH_D-1:0] i_rdata,
   output logic [WIDTH_D-1:0] d_addr,
   output logic [WIDTH_D-1:0] d_wdata,
   output logic               d_we,
   input  logic [WIDTH_D-1:0] d_rdata
);
   cpu_state_e         st_q, st_d;
   logic [DEPTH_I-1:0] pc_q, pc_d;
   logic [WIDTH_D-1:0] regs_q [4];
   logic [WIDTH_D-1:0] regs_d [4];
   logic [3:0]         op;
   logic [1:0]         rd;
   logic [15:0]        imm;
   logic               unused_instr;

   assign op           = i_rdata[WIDTH_D-1 -: 4];
   assign rd           = i_rdata[25:24];
   assign imm          = i_rdata[15:0];
   assign unused_instr = ^{i_rdata[27:26], i_rdata[23:16]};
   assign i_addr       = pc_q;

   always_comb begin
      st_d    = st_q;
      pc_d    = pc_q;
      regs_d  = regs_q;
      d_addr  = WIDTH_D'(imm);
      d_wdata = regs_q[rd];
      d_we    = 1'b0;
      case (st_q)
         CPU_HALT:  if (resume) st_d = CPU_FETCH;
         CPU_FETCH: st_d = CPU_EXEC;
         CPU_EXEC: begin
            st_d = CPU_FETCH;
            pc_d = pc_q + 1'b1;
            case (op)
               OP_LI:  regs_d[rd] = WIDTH_D'(imm);
               OP_SW:  d_we = 1'b1;
               OP_LW: begin
                  st_d = CPU_LOAD;
                  pc_d = pc_q;
               end
               OP_JMP: pc_d = imm[DEPTH_I-1:0];
               default: ;
            endcase
         end
         // i_rdata still holds the LW word: pc has not moved
         CPU_LOAD: begin
            regs_d[rd] = d_rdata;
            pc_d       = pc_q + 1'b1;
            st_d       = CPU_FETCH;
         end
         default: st_d = CPU_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= CPU_HALT;
         pc_q   <= '0;
         regs_q <= '{default: '0};
      end else begin
         st_q   <= st_d;
         pc_q   <= pc_d;
         regs_q <= regs_d;
      end
   end
endmodule

// File: rtl/sc1_ram.sv
// Generic single-port RAM: synchronous write, registered read (1-cycle latency).
module sc1_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 12
) (
   input  logic             clk,
   input  logic             we,
   input  logic [DEPTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, drops bytes whose
// stop bit is low. byte_valid pulses during the stop-bit sample cycle.
module uart_rx
   import sc1_soc_lite_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int BAUD_HZ = 115200,
   parameter int CNT_W   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data
);
   localparam int BIT_CYCLES = CLK_HZ / BAUD_HZ;
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);

   logic [1:0]       sync_q, sync_d;
   logic             prev_q, prev_d;
   rx_state_e        st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             rx_s, tick;

   assign rx_s      = sync_q[1];
   assign tick      = (cnt_q == '0);
   assign byte_data = shift_q;

   always_comb begin
      sync_d     = {sync_q[0], rxd};
      prev_d     = rx_s;
      st_d       = st_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_valid = 1'b0;
      if (st_q != RX_IDLE && !tick) cnt_d = cnt_q - 1'b1;
      case (st_q)
         RX_IDLE: if (prev_q && !rx_s) begin
            st_d  = RX_START;
            cnt_d = HALF_M1;
         end
         // re-check the start bit at its middle to reject glitches
         RX_START: if (tick) begin
            if (!rx_s) begin
               st_d  = RX_DATA;
               cnt_d = BIT_M1;
               bit_d = 3'd0;
            end else begin
               st_d = RX_IDLE;
            end
         end
         RX_DATA: if (tick) begin
            shift_d = {rx_s, shift_q[7:1]};
            cnt_d   = BIT_M1;
            if (bit_q == 3'd7) st_d = RX_STOP;
            else               bit_d = bit_q + 3'd1;
         end
         RX_STOP: if (tick) begin
            byte_valid = rx_s;
            st_d       = RX_IDLE;
         end
         default: st_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         st_q    <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end
endmodule

// File: rtl/sc1_soc_lite.sv
// SoC wrapper: UART loader owning the RAMs while master=0, CPU with I/O
// registers (LEDs, UART TX) while master=1.
module sc1_soc_lite
   import sc1_soc_lite_pkg::*;
#(
   parameter int UART_CLK_HZ        = 50000000,
   parameter int UART_SCLK_HZ       = 115200,
   parameter int UART_COUNTER_WIDTH = 9,
   parameter int WIDTH_D            = 32,
   parameter int DEPTH_I            = 12,
   parameter int DEPTH_D            = 12,
   parameter int DEPTH_IO_REG       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic [9:0] led
);
   localparam int BIT_CYCLES = UART_CLK_HZ / UART_SCLK_HZ;
   localparam logic [UART_COUNTER_WIDTH-1:0] TX_BIT_M1 = UART_COUNTER_WIDTH'(BIT_CYCLES - 1);
   localparam int IO_N = 1 << DEPTH_IO_REG;
   localparam logic [31:0] I_WORDS = 32'(1) << DEPTH_I;
   localparam logic [31:0] D_WORDS = 32'(1) << DEPTH_D;

   logic       rx_valid;
   logic [7:0] rx_data;

   uart_rx #(
      .CLK_HZ  (UART_CLK_HZ),
      .BAUD_HZ (UART_SCLK_HZ),
      .CNT_W   (UART_COUNTER_WIDTH)
   ) u_uart_rx (
      .clk        (clk),
      .rst        (reset),
      .rxd        (uart_rxd),
      .byte_valid (rx_valid),
      .byte_data  (rx_data)
   );

   ld_state_e   ld_st_q, ld_st_d;
   logic [31:0] ld_addr_q, ld_addr_d, ld_data_q, ld_data_d;
   logic        ld_fire;
   logic        cpu_reset_q, cpu_reset_d, resume_q, resume_d, master_q, master_d;

   always_comb begin
      ld_st_d   = ld_st_q;
      ld_addr_d = ld_addr_q;
      ld_data_d = ld_data_q;
      ld_fire   = 1'b0;
      if (rx_valid) begin
         case (ld_st_q)
            LD_IDLE:  if (rx_data == START_BYTE) ld_st_d = LD_ADDR0;
            LD_ADDR0: begin ld_addr_d[7:0]   = rx_data; ld_st_d = LD_ADDR1; end
            LD_ADDR1: begin ld_addr_d[15:8]  = rx_data; ld_st_d = LD_ADDR2; end
            LD_ADDR2: begin ld_addr_d[23:16] = rx_data; ld_st_d = LD_ADDR3; end
            LD_ADDR3: begin ld_addr_d[31:24] = rx_data; ld_st_d = LD_DATA0; end
            LD_DATA0: begin ld_data_d[7:0]   = rx_data; ld_st_d = LD_DATA1; end
            LD_DATA1: begin ld_data_d[15:8]  = rx_data; ld_st_d = LD_DATA2; end
            LD_DATA2: begin ld_data_d[23:16] = rx_data; ld_st_d = LD_DATA3; end
            LD_DATA3: begin ld_data_d[31:24] = rx_data; ld_st_d = LD_END;   end
            LD_END: begin
               ld_fire = (rx_data == END_BYTE);
               ld_st_d = LD_IDLE;
            end
            default: ld_st_d = LD_IDLE;
         endcase
      end
   end

   // unsigned wrap makes (addr - base) < size a full range check
   logic [31:0] off_i, off_d;
   logic        ld_we_i, ld_we_d;

   assign off_i   = ld_addr_q - ADDR_I_BASE;
   assign off_d   = ld_addr_q - ADDR_D_BASE;
   assign ld_we_i = ld_fire && !master_q && (off_i < I_WORDS);
   assign ld_we_d = ld_fire && !master_q && (off_d < D_WORDS);

   always_comb begin
      cpu_reset_d = cpu_reset_q;
      resume_d    = resume_q;
      master_d    = master_q;
      if (ld_fire) begin
         if (ld_addr_q == ADDR_CPU_RESET) cpu_reset_d = ld_data_q[0];
         if (ld_addr_q == ADDR_RESUME)    resume_d    = ld_data_q[0];
         if (ld_addr_q == ADDR_MASTER)    master_d    = ld_data_q[0];
      end
   end

   logic               cpu_rst, cpu_d_we;
   logic [DEPTH_I-1:0] cpu_i_addr;
   logic [WIDTH_D-1:0] cpu_i_rdata, cpu_d_addr, cpu_d_wdata, cpu_d_rdata;

   assign cpu_rst = reset | cpu_reset_q;

   sc1_cpu #(
      .WIDTH_D (WIDTH_D),
      .DEPTH_I (DEPTH_I)
   ) u_cpu (
      .clk     (clk),
      .rst     (cpu_rst),
      .resume  (resume_q),
      .i_addr  (cpu_i_addr),
      .i_rdata (cpu_i_rdata),
      .d_addr  (cpu_d_addr),
      .d_wdata (cpu_d_wdata),
      .d_we    (cpu_d_we),
      .d_rdata (cpu_d_rdata)
   );

   logic                    cpu_io_sel, cpu_io_we, cpu_dram_we;
   logic [DEPTH_IO_REG-1:0] io_idx;
   logic [WIDTH_D-1:0]      mem_d_rdata;
   logic                    unused_cpu_addr;

   assign cpu_io_sel      = cpu_d_addr[DEPTH_D];
   assign io_idx          = cpu_d_addr[DEPTH_IO_REG-1:0];
   assign cpu_io_we       = master_q && cpu_d_we && cpu_io_sel;
   assign cpu_dram_we     = cpu_d_we && !cpu_io_sel;
   assign unused_cpu_addr = ^cpu_d_addr[WIDTH_D-1:DEPTH_D+1];

   sc1_ram #(.WIDTH(WIDTH_D), .DEPTH(DEPTH_I)) mem_i (
      .clk   (clk),
      .we    (ld_we_i),
      .addr  (master_q ? cpu_i_addr : off_i[DEPTH_I-1:0]),
      .wdata (WIDTH_D'(ld_data_q)),
      .rdata (cpu_i_rdata)
   );

   sc1_ram #(.WIDTH(WIDTH_D), .DEPTH(DEPTH_D)) mem_d (
      .clk   (clk),
      .we    (master_q ? cpu_dram_we : ld_we_d),
      .addr  (master_q ? cpu_d_addr[DEPTH_D-1:0] : off_d[DEPTH_D-1:0]),
      .wdata (master_q ? cpu_d_wdata : WIDTH_D'(ld_data_q)),
      .rdata (mem_d_rdata)
   );

   logic [WIDTH_D-1:0]            io_reg_q [IO_N];
   logic [WIDTH_D-1:0]            io_reg_d [IO_N];
   logic                          io_sel_q, io_sel_d;
   logic [WIDTH_D-1:0]            io_rdata_q, io_rdata_d;
   logic                          tx_busy_q, tx_busy_d, txd_q, txd_d, tx_start;
   logic [UART_COUNTER_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]                    tx_left_q, tx_left_d;
   logic [7:0]                    tx_shift_q, tx_shift_d;

   assign tx_start    = cpu_io_we && (io_idx == DEPTH_IO_REG'(IO_TX)) && !tx_busy_q;
   assign cpu_d_rdata = io_sel_q ? io_rdata_q : mem_d_rdata;
   assign led         = io_reg_q[IO_LED][9:0];
   assign uart_txd    = txd_q;

   always_comb begin
      io_reg_d   = io_reg_q;
      io_sel_d   = cpu_io_sel;
      io_rdata_d = (io_idx == DEPTH_IO_REG'(IO_TX_STAT)) ? WIDTH_D'(tx_busy_q) : io_reg_q[io_idx];
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_left_d  = tx_left_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      if (cpu_io_we) io_reg_d[io_idx] = cpu_d_wdata;
      // start bit goes out now; 8 data bits then the stop bit follow
      if (tx_start) begin
         tx_busy_d  = 1'b1;
         tx_cnt_d   = TX_BIT_M1;
         tx_left_d  = 4'd9;
         tx_shift_d = cpu_d_wdata[7:0];
         txd_d      = 1'b0;
      end else if (tx_busy_q) begin
         if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
         end else if (tx_left_q == 4'd0) begin
            tx_busy_d = 1'b0;
         end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[7:1]};
            tx_left_d  = tx_left_q - 4'd1;
            tx_cnt_d   = TX_BIT_M1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_st_q     <= LD_IDLE;
         ld_addr_q   <= '0;
         ld_data_q   <= '0;
         cpu_reset_q <= 1'b0;
         resume_q    <= 1'b0;
         master_q    <= 1'b1;
         io_reg_q    <= '{default: '0};
         io_sel_q    <= 1'b0;
         io_rdata_q  <= '0;
         tx_busy_q   <= 1'b0;
         tx_cnt_q    <= '0;
         tx_left_q   <= '0;
         tx_shift_q  <= '0;
         txd_q       <= 1'b1;
      end else begin
         ld_st_q     <= ld_st_d;
         ld_addr_q   <= ld_addr_d;
         ld_data_q   <= ld_data_d;
         cpu_reset_q <= cpu_reset_d;
         resume_q    <= resume_d;
         master_q    <= master_d;
         io_reg_q    <= io_reg_d;
         io_sel_q    <= io_sel_d;
         io_rdata_q  <= io_rdata_d;
         tx_busy_q   <= tx_busy_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_left_q   <= tx_left_d;
         tx_shift_q  <= tx_shift_d;
         txd_q       <= txd_d;
      end
   end
endmodule

// File: tb/tb_sc1_soc_lite.sv
// Directed bench for sc1_soc_lite: UART loader frames, download, hand-back,
// CPU LED/TX stores and mid-frame reset, with 2-cycle bit period.
module tb_sc1_soc_lite;
   import sc1_soc_lite_pkg::*;

   localparam int BIT = 2;

   logic       clk, reset, uart_rxd, uart_txd;
   logic [9:0] led;
   int         n_chk = 0, n_fail = 0;
   logic       rst_done = 1'b0;

   sc1_soc_lite #(
      .UART_CLK_HZ(2), .UART_SCLK_HZ(1), .UART_COUNTER_WIDTH(9),
      .WIDTH_D(32), .DEPTH_I(12), .DEPTH_D(12), .DEPTH_IO_REG(4)
   ) dut (
      .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .led(led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      uart_rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      uart_rxd = 1'b1;
      repeat (3*BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input logic [7:0] e);
      send_byte(8'hAA);
      for (int i = 0; i < 4; i++) send_byte(8'((a >> (8*i)) & 32'hFF));
      for (int i = 0; i < 4; i++) send_byte(8'((d >> (8*i)) & 32'hFF));
      send_byte(e);
      repeat (6) @(negedge clk);
   endtask

   // first CPU fetch and first LED store, observed in the background
   logic        f_seen = 1'b0, st_seen = 1'b0, st_pend = 1'b0;
   logic [11:0] f_pc = '1;
   logic [9:0]  led_before = '1, led_after = '0;

   always @(negedge clk) begin
      if (!f_seen && dut.u_cpu.st_q == CPU_FETCH) begin
         f_seen <= 1'b1;
         f_pc   <= dut.u_cpu.pc_q;
      end
      if (st_pend) begin
         led_after <= led;
         st_pend   <= 1'b0;
         st_seen   <= 1'b1;
      end
      if (!st_seen && !st_pend && dut.cpu_io_we && dut.io_idx == 4'd0) begin
         led_before <= led;
         st_pend    <= 1'b1;
      end
   end

   // UART TX decoder: sample each bit in its middle
   logic       tx_done = 1'b0, tx_stop = 1'b0;
   logic [7:0] tx_byte = '0;

   initial begin
      logic found;
      found = 1'b0;
      wait (rst_done);
      for (int c = 0; c < 30000 && !found; c++) begin
         @(negedge clk);
         if (uart_txd == 1'b0) found = 1'b1;
      end
      if (found) begin
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            tx_byte[i] = uart_txd;
         end
         repeat (BIT) @(negedge clk);
         tx_stop = uart_txd;
         tx_done = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   logic [31:0] prog [14];

   initial begin
      prog = '{32'h30040003, 32'h110002A5, 32'h21001000, 32'h12000041,
               32'h22001001, 32'h40000005, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h00000001};
      reset    = 1'b1;
      uart_rxd = 1'b1;
      repeat (4) @(negedge clk);
      reset    = 1'b0;
      rst_done = 1'b1;
      @(negedge clk);

      check("rst_txd",       32'(uart_txd),         32'h1);
      check("rst_led",       32'(led),              32'h0);
      check("rst_master",    32'(dut.master_q),     32'h1);
      check("rst_cpu_reset", 32'(dut.cpu_reset_q),  32'h0);
      check("rst_resume",    32'(dut.resume_q),     32'h0);
      check("rst_ld_state",  32'(dut.ld_st_q),      32'(LD_IDLE));

      send_frame(32'h5000, 32'h1, 8'h55);
      check("ctl_cpu_reset", 32'(dut.cpu_reset_q), 32'h1);
      send_frame(32'h5002, 32'h0, 8'h55);
      check("ctl_master",    32'(dut.master_q),    32'h0);
      check("ctl_cpu_held",  32'(dut.cpu_rst),     32'h1);

      for (int i = 0; i < 14; i++) send_frame(32'h4000 + 32'(i), prog[i], 8'h55);
      send_frame(32'h0003, 32'h12345678, 8'h55);
      send_frame(32'h0000, 32'h11111111, 8'h55);
      check("dl_mem_i0",  dut.mem_i.mem[0],  32'h30040003);
      check("dl_mem_i13", dut.mem_i.mem[13], 32'h00000001);
      check("dl_mem_i5",  dut.mem_i.mem[5],  32'h40000005);
      check("dl_mem_d3",  dut.mem_d.mem[3],  32'h12345678);

      send_frame(32'h4000, 32'hDEADBEEF, 8'h56);
      check("bad_end", dut.mem_i.mem[0], 32'h30040003);
      send_byte(8'h12);
      send_frame(32'h4006, 32'hCAFEF00D, 8'h55);
      check("lead_junk", dut.mem_i.mem[6], 32'hCAFEF00D);
      send_frame(32'h1000, 32'hBADBAD00, 8'h55);
      check("oob_addr", dut.mem_d.mem[0], 32'h11111111);

      send_frame(32'h5002, 32'h1, 8'h55);
      check("hb_master", 32'(dut.master_q), 32'h1);
      send_frame(32'h400A, 32'hFFFFFFFF, 8'h55);
      check("master_blocks_ld", dut.mem_i.mem[10], 32'h0);
      send_frame(32'h5000, 32'h0, 8'h55);
      check("hb_cpu_reset", 32'(dut.cpu_reset_q), 32'h0);
      check("hb_cpu_halt",  32'(dut.u_cpu.st_q),  32'(CPU_HALT));
      send_frame(32'h5001, 32'h1, 8'h55);
      check("hb_resume_on", 32'(dut.resume_q), 32'h1);

      for (int c = 0; c < 400 && !tx_done; c++) @(negedge clk);
      check("first_fetch_seen", 32'(f_seen),     32'h1);
      check("first_fetch_pc",   32'(f_pc),       32'h0);
      check("led_store_seen",   32'(st_seen),    32'h1);
      check("led_before_store", 32'(led_before), 32'h0);
      check("led_after_store",  32'(led_after),  32'h2A5);
      check("cpu_lw_r0",        dut.u_cpu.regs_q[0], 32'h12345678);
      check("tx_done",          32'(tx_done),    32'h1);
      check("tx_byte",          32'(tx_byte),    32'h41);
      check("tx_stop",          32'(tx_stop),    32'h1);

      send_frame(32'h5001, 32'h0, 8'h55);
      check("hb_resume_off", 32'(dut.resume_q), 32'h0);

      send_frame(32'h5000, 32'h1, 8'h55);
      send_frame(32'h5002, 32'h0, 8'h55);
      send_byte(8'hAA);
      send_byte(8'h00); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h44); send_byte(8'h33);
      check("mid_state_data2", 32'(dut.ld_st_q), 32'(LD_DATA2));
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      uart_rxd = 1'b1;
      reset    = 1'b1;
      repeat (3) @(negedge clk);
      reset    = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_ld_idle",   32'(dut.ld_st_q),     32'(LD_IDLE));
      check("mid_master",    32'(dut.master_q),    32'h1);
      check("mid_cpu_reset", 32'(dut.cpu_reset_q), 32'h0);
      check("mid_resume",    32'(dut.resume_q),    32'h0);
      check("mid_led",       32'(led),             32'h0);
      check("mid_io_tx",     dut.io_reg_q[1],      32'h0);
      check("mid_mem_i0",    dut.mem_i.mem[0],     32'h30040003);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
